// File: rtl/gain_mix_stage.sv
// Two-stage valid/ready gain-and-mix stage: out = sat(round(a*gain >> GAIN_FRAC) + b).
// Clamped samples are flagged on out_sat and tallied in a saturating sat_count.
module gain_mix_stage #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned GAIN_FRAC = 14,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [GAIN_W-1:0] in_gain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  sat_count
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned TOP_W  = PROD_W - DATA_W + 1;
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (GAIN_FRAC - 1);

  logic                     s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic signed [DATA_W-1:0] s1_b_q, s1_b_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic [CNT_W-1:0]         sat_count_q, sat_count_d;

  logic                     s2_load, s1_load;
  logic signed [PROD_W-1:0] rounded, scaled, sum;
  logic [TOP_W-1:0]         top;
  logic                     clip;

  always_comb begin
    s2_load = !out_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;

    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_b_d     = s1_b_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_prod_d = PROD_W'($signed(in_a)) * PROD_W'($signed(in_gain));
        s1_b_d    = $signed(in_b);
      end
    end

    // Scaled value and sum are carried at full product width; the scaled
    // value fits in PROD_W-GAIN_FRAC bits so the wider sum cannot overflow.
    rounded = s1_prod_q + RND_HALF;
    scaled  = rounded >>> GAIN_FRAC;
    sum     = scaled + PROD_W'(s1_b_q);
    top     = sum[PROD_W-1:DATA_W-1];
    clip    = !((top == '0) || (top == '1));

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sat_d = clip;
        if (!clip)
          out_data_d = sum[DATA_W-1:0];
        else if (sum[PROD_W-1])
          out_data_d = {1'b1, {(DATA_W-1){1'b0}}};
        else
          out_data_d = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end

    sat_count_d = sat_count_q;
    if (clr_count)
      sat_count_d = '0;
    else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1))
      sat_count_d = sat_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_gain_mix_stage.sv
// Directed bench for gain_mix_stage: mix, rounding, clamp, backpressure,
// counter limit (second instance with a 2-bit counter) and mid-stream reset.
module tb_gain_mix_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, clr_count;
  logic [15:0] in_a, in_b, in_gain;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_data, sat_count;
  logic        c_in_ready, c_out_valid, c_out_sat;
  logic [15:0] c_out_data;
  logic [1:0]  c_sat_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gain_mix_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_gain(in_gain),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .clr_count(clr_count), .sat_count(sat_count)
  );

  gain_mix_stage #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_a(in_a), .in_b(in_b), .in_gain(in_gain),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .out_sat(c_out_sat), .clr_count(clr_count), .sat_count(c_sat_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int g);
    in_a    = 16'(a);
    in_b    = 16'(b);
    in_gain = 16'(g);
  endtask

  // Single sample through an idle pipeline with out_ready high.
  task automatic send_one(input string tag, input int a, input int b, input int g,
                          input logic [15:0] ed, input logic es);
    @(negedge clk);
    drive(a, b, g);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_sat"}, 32'(out_sat), 32'(es));
    @(negedge clk);
    chk({tag, "_drain"}, 32'(out_valid), 0);
  endtask

  function automatic void model(input int a, input int b, input int g,
                                output logic [15:0] d, output logic s);
    longint p, sc, sm;
    p  = longint'(a) * longint'(g);
    sc = (p + 64'sd8192) >>> 14;
    sm = sc + longint'(b);
    if (sm > 32767) begin
      d = 16'h7FFF; s = 1'b1;
    end else if (sm < -32768) begin
      d = 16'h8000; s = 1'b1;
    end else begin
      d = 16'(sm); s = 1'b0;
    end
  endfunction

  int          sa[10], sb[10], sg[10];
  logic [15:0] ed[10];
  logic        es[10];
  int          sidx, ridx, occ;
  logic        saw_full;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
    drive(0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sat", 32'(out_sat), 0);
    chk("rst_sat_count", 32'(sat_count), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    send_one("unity", 1000, 2000, 16'h4000, 16'd3000, 1'b0);
    send_one("rnd_p1", 1, 0, 16'h2000, 16'd1, 1'b0);
    send_one("rnd_m1", -1, 0, 16'h2000, 16'd0, 1'b0);
    send_one("rnd_p3", 3, 0, 16'h2000, 16'd2, 1'b0);
    send_one("sat_pos", 16'h7FFF, 16'h7FFF, 16'h4000, 16'h7FFF, 1'b1);
    send_one("sat_neg", -32768, -32768, 16'h7FFF, 16'h8000, 1'b1);
    chk("sat_count_2", 32'(sat_count), 2);
    chk("c_sat_count_2", 32'(c_sat_count), 2);

    for (int i = 0; i < 10; i++) begin
      sa[i] = -3000 + i * 1500;
      sb[i] = 1000 * i - 2000;
      sg[i] = 16384 + i * 1024;
      model(sa[i], sb[i], sg[i], ed[i], es[i]);
    end
    sidx = 0; ridx = 0; occ = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 40 && ridx < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sidx < 10) begin
        drive(sa[sidx], sb[sidx], sg[sidx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'((occ < 2) || out_ready));
      if (!in_ready) saw_full = 1'b1;
      if (out_valid) begin
        if (ridx < 10) begin
          chk("bp_data", 32'(out_data), 32'(ed[ridx]));
          chk("bp_sat", 32'(out_sat), 32'(es[ridx]));
          if (out_ready) begin
            ridx++;
            occ--;
          end
        end else begin
          chk("bp_extra", 32'(out_valid), 0);
        end
      end
      if (in_valid && in_ready) begin
        sidx++;
        occ++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_out", 32'(ridx), 10);
    chk("bp_saw_full", 32'(saw_full), 1);

    @(negedge clk);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("clr_main", 32'(sat_count), 0);
    chk("clr_c", 32'(c_sat_count), 0);

    @(negedge clk);
    drive(32767, 32767, 16384);
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("lim_c_sticky", 32'(c_sat_count), 3);
    chk("lim_main_5", 32'(sat_count), 5);

    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clrwin_valid", 32'(out_valid), 1);
    chk("clrwin_sat", 32'(out_sat), 1);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("clrwin_main", 32'(sat_count), 0);
    chk("clrwin_c", 32'(c_sat_count), 0);

    @(negedge clk);
    drive(1000, 0, 16384);
    in_valid = 1'b1;
    @(negedge clk);
    drive(2000, 0, 16384);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mrst_pre_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mrst_no_stale", 32'(out_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
